// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one 2**DIVISOR_BITS-cycle delay counter among requesters, round-robin by default; define TIMER_ARB_FIXED_PRIO_EN for fixed lowest-index priority
module timer_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_BITS      = 2,
  parameter int DIVISOR_BITS = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [ID_BITS-1:0] cur_id,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, COUNT, RELEASE} state_t;
  localparam logic [DIVISOR_BITS-1:0] CNT_LAST = '1;
  state_t                  r_state, w_state;
  logic [NUM_REQ-1:0]      r_grant, w_grant, r_done, w_done;
  logic [ID_BITS-1:0]      r_cur_id, w_cur_id, w_win;
  logic [DIVISOR_BITS-1:0] r_cnt, w_cnt;
  logic                    r_busy, w_own;
  int                      w_start;
`ifdef TIMER_ARB_FIXED_PRIO_EN
  assign w_start = 0;
`else
  logic [ID_BITS-1:0] r_last, w_last;
  assign w_start = (int'(r_last) >= NUM_REQ - 1) ? 0 : int'(r_last) + 1;
`endif
  assign w_own = |(req & r_grant);
  // winner: lowest requester at or above the scan start, else lowest overall (wrap-around)
  always_comb begin
    w_win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i]) w_win = ID_BITS'(i);
    for (int i = NUM_REQ - 1; i >= 0; i--) if (req[i] && i >= w_start) w_win = ID_BITS'(i);
  end
  // next state and next registered outputs; done defaults low so it only ever pulses
  always_comb begin
    w_state  = r_state;
    w_grant  = r_grant;
    w_done   = '0;
    w_cur_id = r_cur_id;
    w_cnt    = r_cnt;
`ifndef TIMER_ARB_FIXED_PRIO_EN
    w_last   = r_last;
`endif
    case (r_state)
      IDLE: if (|req) begin
        w_state  = COUNT;
        w_grant  = NUM_REQ'(1) << w_win;
        w_cur_id = w_win;
        w_cnt    = '0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
        w_last   = w_win;
`endif
      end
      COUNT: if (!w_own) begin
        w_state  = IDLE;
        w_grant  = '0;
        w_cur_id = '0;
        w_cnt    = '0;
      end else if (r_cnt == CNT_LAST) begin
        w_state  = RELEASE;
        w_done   = r_grant;
        w_cnt    = '0;
      end else begin
        w_cnt    = r_cnt + 1'b1;
      end
      default: if (!w_own) begin
        w_state  = IDLE;
        w_grant  = '0;
        w_cur_id = '0;
      end
    endcase
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_cur_id <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
      r_last   <= ID_BITS'(NUM_REQ - 1);
`endif
    end else begin
      r_state  <= w_state;
      r_grant  <= w_grant;
      r_done   <= w_done;
      r_cur_id <= w_cur_id;
      r_cnt    <= w_cnt;
      r_busy   <= (w_state != IDLE);
`ifndef TIMER_ARB_FIXED_PRIO_EN
      r_last   <= w_last;
`endif
    end
  end
  assign grant  = r_grant;
  assign done   = r_done;
  assign cur_id = r_cur_id;
  assign busy   = r_busy;
endmodule
